// File: rtl/clk_div_param.sv
// clk_div_param
//   Parametrised integer clock divider with a valid/ready reconfiguration
//   handshake, a glitch-free change of ratio at a period boundary (with a
//   programmable low-parked gap), a synchronised external gate and a
//   one-cycle enable pulse marking each divided rising edge.
//
// Ports
//   clk_i         source clock
//   rst_i         synchronous active-high reset
//   test_mode_i   DFT mode, forces clk_o = clk_i (combinational mux)
//   gate_async_i  asynchronous run enable, 1 = run
//   cfg_div_i     requested divider value
//   cfg_valid_i   request valid
//   cfg_ready_o   request can be accepted (high only in RUN)
//   div_o         divider value currently in effect
//   busy_o        reconfiguration in progress (PEND or HOLD)
//   clk_en_o      one-cycle pulse in the cycle clk_o goes high
//   clk_o         divided clock (registered unless in test mode)
module clk_div_param #(
    parameter int DIV_WIDTH   = 8,
    parameter int DIV_INIT    = 2,
    parameter int GAP_CYCLES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 test_mode_i,
    input  logic                 gate_async_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 busy_o,
    output logic                 clk_en_o,
    output logic                 clk_o
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DIV_WIDTH-1:0] DIV_RST  = (DIV_INIT < 2) ? DIV_WIDTH'(2) : DIV_WIDTH'(DIV_INIT);
    localparam logic [DIV_WIDTH-1:0] CNT_RST  = DIV_RST - DIV_WIDTH'(1);
    localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Divide ratios below 2 cannot produce a clock; saturate them to 2.
    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
        return (v < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : v;
    endfunction

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [DIV_WIDTH-1:0]   pend_q;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   clk_q, clk_d;
    logic                   en_q, en_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic                   gate_s;
    logic                   accept;
    logic                   at_bound;
    logic [DIV_WIDTH-1:0]   last_cnt;
    logic [DIV_WIDTH-1:0]   cnt_inc;
    logic [DIV_WIDTH-1:0]   high_len;

    assign gate_s   = sync_q[SYNC_STAGES-1];
    assign accept   = (state_q == RUN) && cfg_valid_i;
    assign last_cnt = div_q - DIV_WIDTH'(1);
    assign cnt_inc  = cnt_q + DIV_WIDTH'(1);
    // ceil(N/2): the high phase takes the extra cycle of an odd ratio.
    assign high_len = div_q - (div_q >> 1);
    // >= rather than == so an out-of-range count can never run away.
    assign at_bound = (cnt_q >= last_cnt);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (cfg_valid_i)       state_d = PEND;
            PEND:    if (at_bound)          state_d = HOLD;
            HOLD:    if (gap_q == '0)       state_d = RUN;
            default:                        state_d = RUN;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        gap_d = gap_q;
        clk_d = 1'b0;
        en_d  = 1'b0;
        case (state_q)
            HOLD: begin
                // Counter frozen, clock parked low; on the last gap cycle the
                // new ratio is loaded parked at its own period boundary.
                if (gap_q == '0) begin
                    div_d = pend_q;
                    cnt_d = pend_q - DIV_WIDTH'(1);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                if (state_q == PEND && at_bound) begin
                    // Old period has finished low: freeze here and start the gap.
                    gap_d = GAP_LOAD;
                end else if (at_bound) begin
                    // Gate is only honoured at the boundary, so a gate change
                    // can never cut a phase short.
                    if (gate_s) begin
                        cnt_d = '0;
                        clk_d = 1'b1;
                        en_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    clk_d = (cnt_inc < high_len);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= CNT_RST;
            div_q  <= DIV_RST;
            gap_q  <= '0;
            clk_q  <= 1'b0;
            en_q   <= 1'b0;
            sync_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            gap_q  <= gap_d;
            clk_q  <= clk_d;
            en_q   <= en_d;
            sync_q <= {sync_q[SYNC_STAGES-2:0], gate_async_i};
        end
    end

    // Pending ratio is pure data; it is only read after an accept.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            pend_q <= clamp_div(cfg_div_i);
        end
    end

    assign cfg_ready_o = (state_q == RUN);
    assign busy_o      = (state_q != RUN);
    assign div_o       = div_q;
    assign clk_en_o    = en_q;
    assign clk_o       = test_mode_i ? clk_i : clk_q;

endmodule

// File: tb/tb_clk_div_param.sv
// tb_clk_div_param
//   Directed bench for clk_div_param (DIV_INIT=4, GAP_CYCLES=2,
//   SYNC_STAGES=2). Expected waveforms are hand-derived bit patterns,
//   listed left to right in time order.
module tb_clk_div_param;

    localparam int DW = 8;

    logic          clk_i;
    logic          rst_i;
    logic          test_mode_i;
    logic          gate_async_i;
    logic [DW-1:0] cfg_div_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [DW-1:0] div_o;
    logic          busy_o;
    logic          clk_en_o;
    logic          clk_o;

    int n_chk  = 0;
    int n_fail = 0;

    clk_div_param #(
        .DIV_WIDTH   (DW),
        .DIV_INIT    (4),
        .GAP_CYCLES  (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .test_mode_i  (test_mode_i),
        .gate_async_i (gate_async_i),
        .cfg_div_i    (cfg_div_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .div_o        (div_o),
        .busy_o       (busy_o),
        .clk_en_o     (clk_en_o),
        .clk_o        (clk_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clk_i cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Run n cycles, checking clk_o, clk_en_o, busy_o and cfg_ready_o each cycle.
    task automatic seq(input string tag, input int n, input logic [63:0] clk_pat,
                       input logic [63:0] en_pat, input logic [63:0] busy_pat);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_clk%0d", tag, i),   clk_o,       clk_pat[n-1-i]);
            chk($sformatf("%s_en%0d", tag, i),    clk_en_o,    en_pat[n-1-i]);
            chk($sformatf("%s_busy%0d", tag, i),  busy_o,      busy_pat[n-1-i]);
            chk($sformatf("%s_ready%0d", tag, i), cfg_ready_o, !busy_pat[n-1-i]);
        end
    endtask

    // Present a request for one cycle (accepted immediately in RUN), then
    // withdraw it and scramble the data bus.
    task automatic cfg_req(input string tag, input logic [DW-1:0] d,
                           input logic exp_clk, input logic exp_en);
        cfg_valid_i = 1'b1;
        cfg_div_i   = d;
        tick();
        cfg_valid_i = 1'b0;
        cfg_div_i   = 8'd9;
        chk({tag, "_acc_busy"},  busy_o,      1'b1);
        chk({tag, "_acc_ready"}, cfg_ready_o, 1'b0);
        chk({tag, "_acc_clk"},   clk_o,       exp_clk);
        chk({tag, "_acc_en"},    clk_en_o,    exp_en);
    endtask

    initial begin
        rst_i        = 1'b1;
        test_mode_i  = 1'b0;
        gate_async_i = 1'b1;
        cfg_div_i    = '0;
        cfg_valid_i  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_clk",   clk_o,       1'b0);
        chk("rst_en",    clk_en_o,    1'b0);
        chk("rst_div",   div_o,       8'd4);
        chk("rst_ready", cfg_ready_o, 1'b1);
        chk("rst_busy",  busy_o,      1'b0);
        rst_i = 1'b0;

        // Two gated cycles while the synchroniser fills, then 1,1,0,0
        seq("div4", 10, 10'b0011001100, 10'b0010001000, 10'b0);
        chk("div4_div", div_o, 8'd4);

        // Program 3 at a period boundary: full old period, gap, then 1,1,0
        cfg_req("p3", 8'd3, 1'b1, 1'b1);
        seq("p3", 12, 12'b100000110110, 12'b000000100100, 12'b111110000000);
        chk("p3_div", div_o, 8'd3);

        // Program 0 -> clamped to 2
        cfg_req("p0", 8'd0, 1'b1, 1'b1);
        seq("p0", 7, 7'b1000010, 7'b0000010, 7'b1111000);
        chk("p0_div", div_o, 8'd2);

        // Program 1 -> clamped to 2
        cfg_req("p1", 8'd1, 1'b1, 1'b1);
        seq("p1", 8, 8'b00001010, 8'b00001010, 8'b11100000);
        chk("p1_div", div_o, 8'd2);

        // Program 6
        cfg_req("p6", 8'd6, 1'b1, 1'b1);
        seq("p6", 5, 5'b00001, 5'b00001, 5'b11100);
        chk("p6_div", div_o, 8'd6);

        // Gate dropped in the first high cycle: 3 high, 3 low, then parked low
        gate_async_i = 1'b0;
        seq("goff", 10, 10'b1100000000, 10'b0, 10'b0);
        // Gate back: rises on the third edge with a full 3-cycle high phase
        gate_async_i = 1'b1;
        seq("gon", 6, 6'b001110, 6'b001000, 6'b0);

        // Request 3 then reset while in HOLD; pending value must be dropped
        cfg_req("rh", 8'd3, 1'b0, 1'b0);
        seq("rh", 2, 2'b00, 2'b00, 2'b11);
        rst_i = 1'b1;
        tick();
        chk("rh_rst_busy",  busy_o,      1'b0);
        chk("rh_rst_ready", cfg_ready_o, 1'b1);
        chk("rh_rst_clk",   clk_o,       1'b0);
        chk("rh_rst_en",    clk_en_o,    1'b0);
        chk("rh_rst_div",   div_o,       8'd4);
        rst_i = 1'b0;
        seq("rh_run", 8, 8'b00110011, 8'b00100010, 8'b0);
        chk("rh_run_div", div_o, 8'd4);

        // Program 5, then test mode passes clk_i straight through
        cfg_req("p5", 8'd5, 1'b0, 1'b0);
        seq("p5", 5, 5'b00001, 5'b00001, 5'b11100);
        chk("p5_div", div_o, 8'd5);
        test_mode_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("tm_hi%0d", i), clk_o,    1'b1);
            chk($sformatf("tm_en%0d", i), clk_en_o, 1'b0);
            @(negedge clk_i);
            #1;
            chk($sformatf("tm_lo%0d", i), clk_o, 1'b0);
        end
        test_mode_i = 1'b0;
        // Divider kept running underneath: new period starts exactly here
        seq("tm_exit", 6, 6'b111001, 6'b100001, 6'b0);
        chk("tm_exit_div", div_o, 8'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
